// File: rtl/pipe_fwd_pkg.sv
// ----------------------------------------------------------------------------
// pipe_fwd_pkg
//   Shared types and constants for the pipeline forwarding / hazard unit.
//   - fwd_sel_t   : EX operand-mux select encoding
//   - stage_tag_t : destination tag carried by each pipeline stage
//   - REG_ZERO    : hard-wired zero register, never forwarded, never stalls
//   - tag_match() : the one place a "this tag produces that source" rule lives
// ----------------------------------------------------------------------------
package pipe_fwd_pkg;

    // Width of the register numbers carried in stage tags
    localparam int unsigned REG_W = 5;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic             valid;
        logic             wr;
        logic             is_load;
        logic [REG_W-1:0] dst;
    } stage_tag_t;

    localparam int unsigned TAG_W = $bits(stage_tag_t);

    localparam stage_tag_t TAG_BUBBLE = '{valid: 1'b0, wr: 1'b0, is_load: 1'b0, dst: REG_ZERO};

    // A stage produces src when it is a real, writing instruction targeting a non-zero register equal to src
    function automatic logic tag_match(input stage_tag_t tag, input logic [REG_W-1:0] src);
        return tag.valid & tag.wr & (tag.dst != REG_ZERO) & (tag.dst == src);
    endfunction

endpackage

// File: rtl/pipe_fwd_hazard_unit_cmp.sv
// ----------------------------------------------------------------------------
// pipe_fwd_cmp
//   Compares one ID source operand against the EX and MEM destination tags.
//   Ports:
//     src_i      : ID source register number
//     used_i     : operand is actually read by the instruction
//     ex_tag_i   : packed stage_tag_t of the EX stage
//     mem_tag_i  : packed stage_tag_t of the MEM stage
//     sel_o      : fwd_sel_t the operand will need one cycle later in EX
//     load_hit_o : operand depends on a load currently in EX (load-use)
// ----------------------------------------------------------------------------
module pipe_fwd_cmp
    import pipe_fwd_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic             used_i,
    input  logic [TAG_W-1:0] ex_tag_i,
    input  logic [TAG_W-1:0] mem_tag_i,
    output logic [1:0]       sel_o,
    output logic             load_hit_o
);

    stage_tag_t ex_tag_s;
    stage_tag_t mem_tag_s;
    logic       ex_hit_s;
    logic       mem_hit_s;

    assign ex_tag_s  = stage_tag_t'(ex_tag_i);
    assign mem_tag_s = stage_tag_t'(mem_tag_i);
    assign ex_hit_s  = used_i & tag_match(ex_tag_s, src_i);
    assign mem_hit_s = used_i & tag_match(mem_tag_s, src_i);

    // Select: the instruction in EX is younger than the one in MEM, so it wins
    always_comb begin
        sel_o = FWD_RF;
        if (ex_hit_s) begin
            sel_o = FWD_EXMEM;
        end else if (mem_hit_s) begin
            sel_o = FWD_MEMWB;
        end else begin
            sel_o = FWD_RF;
        end
    end

    assign load_hit_o = ex_hit_s & ex_tag_s.is_load;

endmodule

// File: rtl/pipe_fwd_hazard_unit.sv
// ----------------------------------------------------------------------------
// pipe_fwd_hazard_unit
//   Forwarding and load-use hazard unit for the 5-stage pipeline. Tracks the
//   destination tags of the instructions in EX and MEM and registers per-operand
//   forward selects on the ID->EX transfer edge.
//   Optional feature macro: PIPE_FWD_PERF_EN (adds stall_cnt / fwd_cnt).
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     hold              : freeze all state
//     flush             : squash the instructions in ID and EX
//     id_valid, id_src, id_src_used, id_wr, id_is_load, id_dst : ID instruction
//     stall_o           : combinational load-use stall
//     ex_valid          : EX stage holds a real instruction
//     ex_fwd_sel        : per-port operand select, port p at [2p +: 2]
//     stall_cnt,fwd_cnt : saturating performance counters (macro only)
// ----------------------------------------------------------------------------
module pipe_fwd_hazard_unit
    import pipe_fwd_pkg::*;
#(
    parameter int unsigned NREG_W = REG_W,
    parameter int unsigned NPORT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hold,
    input  logic                    flush,
    input  logic                    id_valid,
    input  logic [NPORT*NREG_W-1:0] id_src,
    input  logic [NPORT-1:0]        id_src_used,
    input  logic                    id_wr,
    input  logic                    id_is_load,
    input  logic [NREG_W-1:0]       id_dst,
    output logic                    stall_o,
    output logic                    ex_valid,
    output logic [2*NPORT-1:0]      ex_fwd_sel
`ifdef PIPE_FWD_PERF_EN
    ,
    output logic [31:0]             stall_cnt,
    output logic [31:0]             fwd_cnt
`endif
);

    // Tags are sized by the package; NREG_W is expected to equal REG_W.
    // No WB tag is kept: nothing forwards out of WB, the register file covers it.
    stage_tag_t ex_tag_q,  ex_tag_d;
    stage_tag_t mem_tag_q, mem_tag_d;
    logic [2*NPORT-1:0] ex_fwd_sel_q, ex_fwd_sel_d;

    logic [2*NPORT-1:0] sel_s;
    logic [NPORT-1:0]   load_hit_s;
    logic               advance_s;

    for (genvar p = 0; p < NPORT; p++) begin : g_cmp
        pipe_fwd_cmp u_cmp (
            .src_i      (id_src[p*NREG_W +: NREG_W]),
            .used_i     (id_src_used[p]),
            .ex_tag_i   (ex_tag_q),
            .mem_tag_i  (mem_tag_q),
            .sel_o      (sel_s[2*p +: 2]),
            .load_hit_o (load_hit_s[p])
        );
    end

    // Flush overrides the load-use stall: the consumer is being squashed anyway
    assign stall_o   = id_valid & ~flush & (|load_hit_s);
    assign advance_s = id_valid & ~stall_o & ~flush;

    // Next-state of the tag pipeline and the registered selects
    always_comb begin
        ex_tag_d     = TAG_BUBBLE;
        ex_fwd_sel_d = '0;
        mem_tag_d    = flush ? TAG_BUBBLE : ex_tag_q;
        if (advance_s) begin
            ex_tag_d     = '{valid: 1'b1, wr: id_wr, is_load: id_is_load, dst: id_dst};
            ex_fwd_sel_d = sel_s;
        end else begin
            ex_tag_d     = TAG_BUBBLE;
            ex_fwd_sel_d = '0;
        end
    end

    // Tag pipeline and select registers; hold freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_tag_q     <= TAG_BUBBLE;
            mem_tag_q    <= TAG_BUBBLE;
            ex_fwd_sel_q <= '0;
        end else if (!hold) begin
            ex_tag_q     <= ex_tag_d;
            mem_tag_q    <= mem_tag_d;
            ex_fwd_sel_q <= ex_fwd_sel_d;
        end
    end

    assign ex_valid   = ex_tag_q.valid;
    assign ex_fwd_sel = ex_fwd_sel_q;

`ifdef PIPE_FWD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q,   fwd_cnt_d;
    logic [31:0] fwd_inc_s;
    logic [32:0] stall_sum_s;
    logic [32:0] fwd_sum_s;

    // Counter next-state: count forwarded fields about to be written, saturate at all-ones
    always_comb begin
        fwd_inc_s = 32'd0;
        for (int p = 0; p < NPORT; p++) begin
            if (ex_fwd_sel_d[2*p +: 2] != 2'b00) begin
                fwd_inc_s = fwd_inc_s + 32'd1;
            end else begin
                fwd_inc_s = fwd_inc_s;
            end
        end
        stall_sum_s = {1'b0, stall_cnt_q} + {32'd0, stall_o};
        fwd_sum_s   = {1'b0, fwd_cnt_q} + {1'b0, fwd_inc_s};
        stall_cnt_d = stall_sum_s[32] ? 32'hFFFF_FFFF : stall_sum_s[31:0];
        fwd_cnt_d   = fwd_sum_s[32]   ? 32'hFFFF_FFFF : fwd_sum_s[31:0];
    end

    // Performance counter registers, frozen by hold like the rest of the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            fwd_cnt_q   <= 32'd0;
        end else if (!hold) begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_fwd_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_pipe_fwd_hazard_unit
//   Directed bench for pipe_fwd_hazard_unit (NPORT=2). Expected EX outputs are
//   queued when an ID instruction is driven and compared after the edge.
// ----------------------------------------------------------------------------
module tb_pipe_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hold;
    logic       flush;
    logic       id_valid;
    logic [9:0] id_src;
    logic [1:0] id_src_used;
    logic       id_wr;
    logic       id_is_load;
    logic [4:0] id_dst;
    logic       stall_o;
    logic       ex_valid;
    logic [3:0] ex_fwd_sel;
`ifdef PIPE_FWD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;
`endif

    int passed = 0;
    int total  = 0;

    typedef struct {
        string      tag;
        logic       valid;
        logic [3:0] sel;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    pipe_fwd_hazard_unit #(.NREG_W(5), .NPORT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (hold),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_wr       (id_wr),
        .id_is_load  (id_is_load),
        .id_dst      (id_dst),
        .stall_o     (stall_o),
        .ex_valid    (ex_valid),
        .ex_fwd_sel  (ex_fwd_sel)
`ifdef PIPE_FWD_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .fwd_cnt     (fwd_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [1:0] used, input logic wr, input logic ld,
                          input logic [4:0] dst);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_wr       = wr;
        id_is_load  = ld;
        id_dst      = dst;
    endtask

    // One clock: check comb stall, queue expected EX outputs, clock, pop and compare
    task automatic cycle(input string tag, input logic exp_stall,
                         input logic exp_valid, input logic [3:0] exp_sel);
        exp_t e;
        #1;
        chk({tag, "_stall"}, {31'd0, stall_o}, {31'd0, exp_stall});
        sb_q.push_back('{tag: tag, valid: exp_valid, sel: exp_sel});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, "_ex_valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
            chk({e.tag, "_ex_fwd_sel"}, {28'd0, ex_fwd_sel}, {28'd0, e.sel});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        set_id(1'b1, 5'd1, 5'd1, 2'b11, 1'b1, 1'b1, 5'd1);
        #12;
        chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_ex_fwd_sel", {28'd0, ex_fwd_sel}, 32'd0);
        chk("reset_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: EX/MEM forward on port 0 only
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 5'd1);
        cycle("s1_prod", 1'b0, 1'b1, 4'b0000);
        set_id(1'b1, 5'd1, 5'd5, 2'b11, 1'b1, 1'b0, 5'd2);
        cycle("s1_cons", 1'b0, 1'b1, 4'b0010);

        // 2: EX and MEM both hold dst=5, newest wins; then mixed 01/10
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 5'd5);
        cycle("s2_p1", 1'b0, 1'b1, 4'b0000);
        cycle("s2_p2", 1'b0, 1'b1, 4'b0000);
        set_id(1'b1, 5'd5, 5'd5, 2'b11, 1'b1, 1'b0, 5'd6);
        cycle("s2_newest", 1'b0, 1'b1, 4'b1010);
        set_id(1'b1, 5'd5, 5'd6, 2'b11, 1'b0, 1'b0, 5'd0);
        cycle("s2_mixed", 1'b0, 1'b1, 4'b1001);

        // 3: load-use, one bubble, then MEM/WB forward
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 5'd7);
        cycle("s3_lw", 1'b0, 1'b1, 4'b0000);
        set_id(1'b1, 5'd7, 5'd3, 2'b11, 1'b1, 1'b0, 5'd8);
        cycle("s3_stall", 1'b1, 1'b0, 4'b0000);
        cycle("s3_after", 1'b0, 1'b1, 4'b0001);
`ifdef PIPE_FWD_PERF_EN
        chk("s3_stall_cnt", stall_cnt, 32'd1);
        chk("s3_fwd_cnt", fwd_cnt, 32'd6);
`endif

        // 4: r0 never forwards/stalls, unused port masks a match
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 5'd0);
        cycle("s4_wr_r0", 1'b0, 1'b1, 4'b0000);
        set_id(1'b1, 5'd0, 5'd0, 2'b11, 1'b0, 1'b0, 5'd0);
        cycle("s4_src_r0", 1'b0, 1'b1, 4'b0000);
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 5'd9);
        cycle("s4_p9", 1'b0, 1'b1, 4'b0000);
        set_id(1'b1, 5'd3, 5'd9, 2'b01, 1'b0, 1'b0, 5'd0);
        cycle("s4_unused", 1'b0, 1'b1, 4'b0000);

        // 5: flush beats load-use and bubbles MEM; then hold freezes state
        set_id(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 5'd10);
        cycle("s5_lw", 1'b0, 1'b1, 4'b0000);
        set_id(1'b1, 5'd10, 5'd0, 2'b01, 1'b1, 1'b0, 5'd11);
        flush = 1'b1;
        cycle("s5_flush", 1'b0, 1'b0, 4'b0000);
        flush = 1'b0;
        cycle("s5_mem_bubble", 1'b0, 1'b1, 4'b0000);
        set_id(1'b1, 5'd11, 5'd0, 2'b01, 1'b1, 1'b1, 5'd12);
        cycle("s5_prehold", 1'b0, 1'b1, 4'b0010);
        set_id(1'b1, 5'd12, 5'd0, 2'b01, 1'b1, 1'b0, 5'd14);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("s5_hold%0d", i), 1'b1, 1'b1, 4'b0010);
        end
        hold = 1'b0;
        cycle("s5_release", 1'b1, 1'b0, 4'b0000);
        cycle("s5_luse", 1'b0, 1'b1, 4'b0001);
`ifdef PIPE_FWD_PERF_EN
        chk("s5_stall_cnt", stall_cnt, 32'd2);
        chk("s5_fwd_cnt", fwd_cnt, 32'd8);
`endif

        // 6: asynchronous reset mid-stream drops all in-flight tags
        set_id(1'b1, 5'd14, 5'd0, 2'b01, 1'b1, 1'b0, 5'd15);
        cycle("s6_pre", 1'b0, 1'b1, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("s6_rst_ex_fwd_sel", {28'd0, ex_fwd_sel}, 32'd0);
`ifdef PIPE_FWD_PERF_EN
        chk("s6_rst_stall_cnt", stall_cnt, 32'd0);
        chk("s6_rst_fwd_cnt", fwd_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        set_id(1'b1, 5'd15, 5'd14, 2'b11, 1'b0, 1'b0, 5'd0);
        cycle("s6_empty", 1'b0, 1'b1, 4'b0000);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
